// File: rtl/ddr3_app_bridge.sv
// Bridges 256-bit cache-line requests onto two 128-bit MIG app_* transactions; all outputs registered.
// Optional debug word (line-transaction count + state code) is built only with DDR3_BRIDGE_DEBUG_EN.
`timescale 1ns/1ps
module ddr3_app_bridge #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [28:0]                   ctrl_addr_i,
  input  logic [2*APP_DATA_WIDTH-1:0]   ctrl_data_i,
  output logic [2*APP_DATA_WIDTH-1:0]   ctrl_data_o,
  input  logic                          ctrl_we_i,
  input  logic                          ctrl_rd_i,
  output logic                          ctrl_ack_o,
  input  logic                          init_calib_complete,
  output logic [APP_ADDR_WIDTH-1:0]     app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
  input  logic                          app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]     app_rd_data,
  input  logic                          app_rd_data_valid,
  output logic [15:0]                   state_value
);

  localparam int       LINE_W = 24;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    S_CALIB    = 3'd0,
    S_BOOT_ACK = 3'd1,
    S_IDLE     = 3'd2,
    S_WR_DATA  = 3'd3,
    S_WR_CMD   = 3'd4,
    S_RD       = 3'd5,
    S_ACK      = 3'd6
  } state_t;

  // beat b of a line lives at {line, b, 3'b000} in 16-bit DQ units
  function automatic logic [APP_ADDR_WIDTH-1:0] beat_addr(input logic [LINE_W-1:0] line,
                                                          input logic beat);
    logic [LINE_W+3:0] a;
    a = {line, beat, 3'b000};
    return APP_ADDR_WIDTH'(a);
  endfunction

  state_t                        r_state, w_state_nxt;
  logic                          r_calib;
  logic                          r_ack, w_ack_nxt;
  logic [2*APP_DATA_WIDTH-1:0]   r_data_o, w_data_o_nxt;
  logic [APP_DATA_WIDTH-1:0]     r_rd_lo, w_rd_lo_nxt;
  logic [APP_DATA_WIDTH-1:0]     r_wr_hi, w_wr_hi_nxt;
  logic [LINE_W-1:0]             r_line, w_line_nxt;
  logic                          r_cmd_idx, w_cmd_idx_nxt;
  logic                          r_beat_idx, w_beat_idx_nxt;
  logic                          r_app_en, w_app_en_nxt;
  logic [APP_ADDR_WIDTH-1:0]     r_app_addr, w_app_addr_nxt;
  logic [2:0]                    r_app_cmd, w_app_cmd_nxt;
  logic                          r_wdf_wren, w_wdf_wren_nxt;
  logic [APP_DATA_WIDTH-1:0]     r_wdf_data, w_wdf_data_nxt;
  logic                          w_unused;

  assign w_unused = ^ctrl_addr_i[4:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_ack_nxt      = 1'b0;
    w_data_o_nxt   = r_data_o;
    w_rd_lo_nxt    = r_rd_lo;
    w_wr_hi_nxt    = r_wr_hi;
    w_line_nxt     = r_line;
    w_cmd_idx_nxt  = r_cmd_idx;
    w_beat_idx_nxt = r_beat_idx;
    w_app_en_nxt   = r_app_en;
    w_app_addr_nxt = r_app_addr;
    w_app_cmd_nxt  = r_app_cmd;
    w_wdf_wren_nxt = r_wdf_wren;
    w_wdf_data_nxt = r_wdf_data;
    case (r_state)
      S_CALIB: begin
        if (r_calib) begin
          w_state_nxt = S_BOOT_ACK;
          w_ack_nxt   = 1'b1;
        end
      end
      S_BOOT_ACK: w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (ctrl_we_i) begin
          w_line_nxt     = ctrl_addr_i[28:5];
          w_wr_hi_nxt    = ctrl_data_i[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH];
          w_wdf_data_nxt = ctrl_data_i[APP_DATA_WIDTH-1:0];
          w_wdf_wren_nxt = 1'b1;
          w_beat_idx_nxt = 1'b0;
          w_state_nxt    = S_WR_DATA;
        end else if (ctrl_rd_i) begin
          w_line_nxt     = ctrl_addr_i[28:5];
          w_app_en_nxt   = 1'b1;
          w_app_cmd_nxt  = CMD_RD;
          w_app_addr_nxt = beat_addr(ctrl_addr_i[28:5], 1'b0);
          w_cmd_idx_nxt  = 1'b0;
          w_beat_idx_nxt = 1'b0;
          w_state_nxt    = S_RD;
        end
      end
      S_WR_DATA: begin
        if (r_wdf_wren && app_wdf_rdy) begin
          if (!r_beat_idx) begin
            w_beat_idx_nxt = 1'b1;
            w_wdf_data_nxt = r_wr_hi;
          end else begin
            w_wdf_wren_nxt = 1'b0;
            w_app_en_nxt   = 1'b1;
            w_app_cmd_nxt  = CMD_WR;
            w_app_addr_nxt = beat_addr(r_line, 1'b0);
            w_cmd_idx_nxt  = 1'b0;
            w_state_nxt    = S_WR_CMD;
          end
        end
      end
      S_WR_CMD: begin
        if (r_app_en && app_rdy) begin
          if (!r_cmd_idx) begin
            w_cmd_idx_nxt  = 1'b1;
            w_app_addr_nxt = beat_addr(r_line, 1'b1);
          end else begin
            w_app_en_nxt = 1'b0;
            w_ack_nxt    = 1'b1;
            w_state_nxt  = S_ACK;
          end
        end
      end
      S_RD: begin
        // command issue and beat capture run independently; beats may overtake command 1
        if (r_app_en && app_rdy) begin
          if (!r_cmd_idx) begin
            w_cmd_idx_nxt  = 1'b1;
            w_app_addr_nxt = beat_addr(r_line, 1'b1);
          end else begin
            w_app_en_nxt = 1'b0;
          end
        end
        if (app_rd_data_valid) begin
          if (!r_beat_idx) begin
            w_rd_lo_nxt    = app_rd_data;
            w_beat_idx_nxt = 1'b1;
          end else begin
            w_data_o_nxt = {app_rd_data, r_rd_lo};
            w_app_en_nxt = 1'b0;
            w_ack_nxt    = 1'b1;
            w_state_nxt  = S_ACK;
          end
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_CALIB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CALIB;
      r_calib    <= 1'b0;
      r_ack      <= 1'b0;
      r_data_o   <= '0;
      r_rd_lo    <= '0;
      r_wr_hi    <= '0;
      r_line     <= '0;
      r_cmd_idx  <= 1'b0;
      r_beat_idx <= 1'b0;
      r_app_en   <= 1'b0;
      r_app_addr <= '0;
      r_app_cmd  <= '0;
      r_wdf_wren <= 1'b0;
      r_wdf_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_calib    <= init_calib_complete;
      r_ack      <= w_ack_nxt;
      r_data_o   <= w_data_o_nxt;
      r_rd_lo    <= w_rd_lo_nxt;
      r_wr_hi    <= w_wr_hi_nxt;
      r_line     <= w_line_nxt;
      r_cmd_idx  <= w_cmd_idx_nxt;
      r_beat_idx <= w_beat_idx_nxt;
      r_app_en   <= w_app_en_nxt;
      r_app_addr <= w_app_addr_nxt;
      r_app_cmd  <= w_app_cmd_nxt;
      r_wdf_wren <= w_wdf_wren_nxt;
      r_wdf_data <= w_wdf_data_nxt;
    end
  end

  assign ctrl_ack_o   = r_ack;
  assign ctrl_data_o  = r_data_o;
  assign app_en       = r_app_en;
  assign app_addr     = r_app_addr;
  assign app_cmd      = r_app_cmd;
  assign app_wdf_wren = r_wdf_wren;
  assign app_wdf_end  = r_wdf_wren;
  assign app_wdf_data = r_wdf_data;
  assign app_wdf_mask = '0;

`ifdef DDR3_BRIDGE_DEBUG_EN
  logic [11:0] r_txn_cnt, w_txn_cnt_nxt;
  logic [15:0] r_state_value;

  always_comb begin
    w_txn_cnt_nxt = r_txn_cnt;
    if (w_state_nxt == S_ACK && r_state != S_ACK) w_txn_cnt_nxt = r_txn_cnt + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txn_cnt     <= '0;
      r_state_value <= '0;
    end else begin
      r_txn_cnt     <= w_txn_cnt_nxt;
      r_state_value <= {w_txn_cnt_nxt, 1'b0, w_state_nxt};
    end
  end

  assign state_value = r_state_value;
`else
  assign state_value = 16'd0;
`endif

endmodule

// File: tb/tb_ddr3_app_bridge.sv
// Bench for ddr3_app_bridge: MIG responder with a memory, line-level reference, directed then random steps.
`timescale 1ns/1ps
module tb_ddr3_app_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [28:0]  ctrl_addr_i;
  logic [255:0] ctrl_data_i, ctrl_data_o;
  logic         ctrl_we_i, ctrl_rd_i, ctrl_ack_o, init_calib_complete;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [15:0]  app_wdf_mask;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic [15:0]  state_value;

  always #5 clk = ~clk;

  ddr3_app_bridge #(.APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .ctrl_addr_i(ctrl_addr_i), .ctrl_data_i(ctrl_data_i), .ctrl_data_o(ctrl_data_o),
    .ctrl_we_i(ctrl_we_i), .ctrl_rd_i(ctrl_rd_i), .ctrl_ack_o(ctrl_ack_o),
    .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .state_value(state_value)
  );

  typedef struct { int cyc; logic [2:0] cmd; logic [27:0] addr; } cmd_t;
  typedef struct { int cyc; logic [127:0] d; } beat_t;
  typedef struct { logic [27:0] addr; int due; } pend_t;

  cmd_t         q_cmd[$];
  beat_t        q_wb[$];
  pend_t        rd_pend[$];
  logic [127:0] wb_pend[$];
  logic [127:0] mem [logic [27:0]];
  logic [255:0] ref_line [logic [23:0]];

  int cyc = 0, ack_cnt = 0, ack_cyc = -1, rv_last = -1;
  int end_viol = 0, stab_viol = 0, cmd_stalls = 0, wdf_stalls = 0;
  int rd_base = 0, last_due = 0, due_t = 0, rd_d0 = 7, rd_d1 = 9;
  int n_chk = 0, n_pass = 0;
  logic [255:0] ack_data = '0;
  logic         p_cmd_stall = 1'b0, p_wdf_stall = 1'b0;
  logic [31:0]  p_cmd_snap = '0;
  logic [128:0] p_wdf_snap = '0;
  logic         rand_rdy = 1'b0, stray = 1'b0;
  int           wdf_stall_left = 0, cmd_stall_left = 0;
  logic [127:0] wdf_stall_match = '0;
  logic [27:0]  cmd_stall_addr = '0;

  function automatic logic [127:0] dflt(input logic [27:0] a);
    return {4{4'hC, a}};
  endfunction

  // line-level reference: whatever was last written to a line, else the MIG's preset content
  function automatic logic [255:0] exp_line(input logic [23:0] ln);
    if (ref_line.exists(ln)) return ref_line[ln];
    return {dflt({ln, 4'b1000}), dflt({ln, 4'b0000})};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // monitor: sampled mid-cycle, logs accepted MIG traffic and acks
  always @(negedge clk) begin
    cyc++;
    if (app_en && app_rdy) begin
      q_cmd.push_back('{cyc, app_cmd, app_addr});
      if (app_cmd == 3'b000) begin
        if (wb_pend.size() > 0) mem[app_addr] = wb_pend.pop_front();
      end else begin
        if (app_addr[3] == 1'b0) begin
          rd_base = cyc;
          due_t   = cyc + rd_d0;
        end else begin
          due_t   = rd_base + rd_d1;
        end
        if (due_t <= cyc) due_t = cyc + 1;
        if (due_t <= last_due) due_t = last_due + 1;
        last_due = due_t;
        rd_pend.push_back('{app_addr, due_t});
      end
    end
    if (app_wdf_wren && app_wdf_rdy) begin
      q_wb.push_back('{cyc, app_wdf_data});
      wb_pend.push_back(app_wdf_data);
    end
    if (app_wdf_end !== app_wdf_wren || app_wdf_mask !== 16'h0) end_viol++;
    if (app_en && !app_rdy) cmd_stalls++;
    if (app_wdf_wren && !app_wdf_rdy) wdf_stalls++;
    if (!rst && p_cmd_stall && ({app_en, app_cmd, app_addr} !== p_cmd_snap)) stab_viol++;
    if (!rst && p_wdf_stall && ({app_wdf_wren, app_wdf_data} !== p_wdf_snap)) stab_viol++;
    p_cmd_stall = app_en && !app_rdy;
    p_cmd_snap  = {app_en, app_cmd, app_addr};
    p_wdf_stall = app_wdf_wren && !app_wdf_rdy;
    p_wdf_snap  = {app_wdf_wren, app_wdf_data};
    if (app_rd_data_valid) rv_last = cyc;
    if (ctrl_ack_o) begin
      ack_cnt++;
      ack_cyc  = cyc;
      ack_data = ctrl_data_o;
    end
  end

  // MIG responder: ready generation and in-order read returns
  initial begin
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
    forever begin
      @(posedge clk);
      #3;
      app_rd_data_valid = 1'b0;
      if (stray) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = {4{32'hDEAD_BEEF}};
        stray             = 1'b0;
      end else if (rd_pend.size() > 0 && rd_pend[0].due <= cyc + 1) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = mem.exists(rd_pend[0].addr) ? mem[rd_pend[0].addr] : dflt(rd_pend[0].addr);
        void'(rd_pend.pop_front());
      end
      app_rdy     = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      app_wdf_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (wdf_stall_left > 0 && app_wdf_wren && app_wdf_data == wdf_stall_match) begin
        app_wdf_rdy = 1'b0;
        wdf_stall_left--;
      end
      if (cmd_stall_left > 0 && app_en && app_addr == cmd_stall_addr) begin
        app_rdy = 1'b0;
        cmd_stall_left--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic set_idle();
    @(posedge clk); #2;
    ctrl_we_i = 1'b0; ctrl_rd_i = 1'b0;
  endtask

  task automatic req(input logic w, input logic r, input logic [28:0] a, input logic [255:0] d,
                     output int t_req, output int t_ack, output logic got);
    int n0;
    @(posedge clk); #2;
    ctrl_we_i = w; ctrl_rd_i = r; ctrl_addr_i = a; ctrl_data_i = d;
    t_req = cyc + 1;
    n0 = ack_cnt; got = 1'b0; t_ack = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (ack_cnt != n0) begin got = 1'b1; t_ack = ack_cyc; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int tr, ta, tr2, ta2, k, n0, exp_acks;
    logic got, got2, w;
    logic [255:0] d, e;
    logic [23:0] ln;

    rst = 1'b1; init_calib_complete = 1'b0; ctrl_we_i = 1'b0; ctrl_rd_i = 1'b0;
    ctrl_addr_i = '0; ctrl_data_i = '0; exp_acks = 0;
    tick(5);
    check("rst_ack",       256'(ctrl_ack_o), 256'(0));
    check("rst_data_o",    ctrl_data_o, 256'(0));
    check("rst_app_en",    256'(app_en), 256'(0));
    check("rst_wren_end",  256'({app_wdf_wren, app_wdf_end}), 256'(0));
    check("rst_addr_cmd",  256'({app_addr, app_cmd}), 256'(0));
    check("rst_wdf_data",  256'(app_wdf_data), 256'(0));
    check("rst_state_val", 256'(state_value), 256'(0));

    // calibration wait, then one boot ack two cycles after the rise
    @(posedge clk); #2; rst = 1'b0;
    tick(20);
    check("calib_no_ack", 256'(ack_cnt), 256'(0));
    @(posedge clk); #2; init_calib_complete = 1'b1; k = cyc + 1;
    tick(6);
    exp_acks++;
    check("boot_ack_cnt", 256'(ack_cnt), 256'(exp_acks));
    check("boot_ack_cyc", 256'(ack_cyc), 256'(k + 2));

    // directed write, MIG always ready
    q_cmd.delete(); q_wb.delete();
    d = {{16{8'hBB}}, {16{8'hAA}}};
    req(1'b1, 1'b0, 29'h0000_0120, d, tr, ta, got);
    set_idle(); tick(3);
    exp_acks++; ref_line[24'h9] = d;
    check("wr_ack_seen", 256'(got), 256'(1));
    check("wr_ack_lat",  256'(ta), 256'(tr + 5));
    check("wr_beat0",    256'({q_wb[0].cyc, q_wb[0].d}), 256'({tr + 1, {16{8'hAA}}}));
    check("wr_beat1",    256'({q_wb[1].cyc, q_wb[1].d}), 256'({tr + 2, {16{8'hBB}}}));
    check("wr_cmd0",     256'({q_cmd[0].cyc, q_cmd[0].cmd, q_cmd[0].addr}), 256'({tr + 3, 3'b000, 28'h0000090}));
    check("wr_cmd1",     256'({q_cmd[1].cyc, q_cmd[1].cmd, q_cmd[1].addr}), 256'({tr + 4, 3'b000, 28'h0000098}));
    check("wr_one_ack",  256'(ack_cnt), 256'(exp_acks));

    // directed read at top of address space, beats 7 and 9 cycles after first command
    q_cmd.delete(); rd_d0 = 7; rd_d1 = 9;
    e = exp_line(24'hFF_FFFF);
    req(1'b0, 1'b1, 29'h1FFF_FFE0, '0, tr, ta, got);
    set_idle(); tick(4);
    exp_acks++;
    check("rd_ack_seen", 256'(got), 256'(1));
    check("rd_ack_data", ack_data, e);
    check("rd_ack_lat",  256'(ta), 256'(rv_last + 1));
    check("rd_cmd0",     256'({q_cmd[0].cmd, q_cmd[0].addr}), 256'({3'b001, 28'hFFFFFF0}));
    check("rd_cmd1",     256'({q_cmd[1].cmd, q_cmd[1].addr}), 256'({3'b001, 28'hFFFFFF8}));
    check("rd_data_hold", ctrl_data_o, e);

    // stalls: 3 cycles on write beat 1, 2 cycles on command 0
    q_cmd.delete(); q_wb.delete(); cmd_stalls = 0; wdf_stalls = 0; n0 = stab_viol;
    d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    wdf_stall_match = d[255:128]; wdf_stall_left = 3;
    cmd_stall_addr = 28'h0000180; cmd_stall_left = 2;
    req(1'b1, 1'b0, 29'h0000_0300, d, tr, ta, got);
    set_idle(); tick(3);
    exp_acks++; ref_line[24'h18] = d;
    check("stall_ack_lat",   256'(ta), 256'(tr + 10));
    check("stall_wdf_cnt",   256'(wdf_stalls), 256'(3));
    check("stall_cmd_cnt",   256'(cmd_stalls), 256'(2));
    check("stall_stable",    256'(stab_viol), 256'(n0));
    check("stall_beat1_cyc", 256'(q_wb[1].cyc), 256'(tr + 5));
    check("stall_cmd0_cyc",  256'(q_cmd[0].cyc), 256'(tr + 8));
    check("stall_one_ack",   256'(ack_cnt), 256'(exp_acks));

    // both requests high (write wins), then read of the same line right after the ack
    q_cmd.delete(); n0 = ack_cnt;
    d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rd_d0 = 2; rd_d1 = 4;
    req(1'b1, 1'b1, 29'h0000_081F, d, tr, ta, got);
    ref_line[24'h40] = d;
    req(1'b0, 1'b1, 29'h0000_0800, '0, tr2, ta2, got2);
    set_idle(); tick(3);
    exp_acks += 2;
    check("b2b_wr_prio",   256'({q_cmd[0].cmd, q_cmd[0].addr}), 256'({3'b000, 28'h0000400}));
    check("b2b_rd_data",   ack_data, d);
    check("b2b_distinct",  256'(got && got2 && ta2 > ta), 256'(1));
    check("b2b_two_acks",  256'(ack_cnt), 256'(n0 + 2));
    check("b2b_rd_cmd",    256'({q_cmd[2].cyc, q_cmd[2].cmd, q_cmd[2].addr}), 256'({tr2 + 1, 3'b001, 28'h0000400}));

    // reset while a read is outstanding, then a stray read beat before recalibration
    q_cmd.delete(); rd_d0 = 30; rd_d1 = 32; n0 = ack_cnt;
    @(posedge clk); #2; ctrl_rd_i = 1'b1; ctrl_addr_i = 29'h1234_5660;
    for (int i = 0; i < 20 && q_cmd.size() == 0; i++) tick(1);
    check("rst_rd_issued", 256'(q_cmd.size() > 0), 256'(1));
    @(posedge clk); #2; rst = 1'b1; ctrl_rd_i = 1'b0; init_calib_complete = 1'b0;
    tick(3);
    @(posedge clk); #2; rst = 1'b0; rd_pend.delete(); wb_pend.delete(); last_due = 0;
    tick(2);
    @(posedge clk); #2; stray = 1'b1;
    tick(4);
    check("abort_no_ack",   256'(ack_cnt), 256'(n0));
    check("stray_ignored",  ctrl_data_o, 256'(0));
    @(posedge clk); #2; init_calib_complete = 1'b1; k = cyc + 1;
    tick(6);
    exp_acks++;
    check("reboot_ack_cnt", 256'(ack_cnt), 256'(n0 + 1));
    check("reboot_ack_cyc", 256'(ack_cyc), 256'(k + 2));
    rd_d0 = 3; rd_d1 = 5;
    req(1'b0, 1'b1, 29'h0000_0120, '0, tr, ta, got);
    set_idle(); tick(2);
    exp_acks++;
    check("post_rst_read", ack_data, exp_line(24'h9));

    // random traffic with random MIG backpressure and read latency
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      w  = 1'($urandom_range(0, 1));
      ln = 24'h000100 + 24'($urandom_range(0, 7));
      d  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rd_d0 = $urandom_range(1, 5);
      rd_d1 = rd_d0 + $urandom_range(1, 4);
      e = exp_line(ln);
      req(w, !w, {ln, 5'($urandom_range(0, 31))}, d, tr, ta, got);
      exp_acks++;
      check("rnd_ack_seen", 256'(got), 256'(1));
      if (w) ref_line[ln] = d;
      else check("rnd_rd_data", ack_data, e);
      k = $urandom_range(0, 2);
      if (k > 0) begin set_idle(); tick(k - 1); end
    end
    set_idle(); tick(6);
    rand_rdy = 1'b0;
    check("total_acks",   256'(ack_cnt), 256'(exp_acks));
    check("stall_stable_all", 256'(stab_viol), 256'(0));
    check("wdf_end_mask", 256'(end_viol), 256'(0));
    check("state_value_off", 256'(state_value), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr3_app_bridge.md
# ddr3_app_bridge

Responder end of the 256-bit cache-line memory interface driven by `ddr3_cache_ctrl`. Each line write or read request is converted into two 128-bit MIG user-interface (app_*) transactions, and the block answers with a single-cycle `ctrl_ack_o`. After calibration it emits one unsolicited boot acknowledge, which releases the cache controller from its init state. It sits between `ddr3_cache_ctrl` and the Xilinx MIG DDR3 core.

## Interface
Parameters:
- `APP_ADDR_WIDTH`, 28: MIG `app_addr` width, in 16-bit DQ units.
- `APP_DATA_WIDTH`, 128: MIG data width. Fixed; a line is exactly 2 beats.

Ports:
- `clk`  in  1  MIG `ui_clk`; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ctrl_addr_i`  in  29  byte address of the line; bits [4:0] ignored.
- `ctrl_data_i`  in  256  write line.
- `ctrl_data_o`  out  256  read line; valid while `ctrl_ack_o`=1.
- `ctrl_we_i`  in  1  line write request, level-held until ack.
- `ctrl_rd_i`  in  1  line read request, level-held until ack.
- `ctrl_ack_o`  out  1  one-cycle completion pulse.
- `init_calib_complete`  in  1  MIG calibration done.
- `app_addr`  out  `APP_ADDR_WIDTH`  command address.
- `app_cmd`  out  3  command: 3'b000 = write, 3'b001 = read.
- `app_en`  out  1  command valid.
- `app_rdy`  in  1  command accepted when both `app_en` and `app_rdy` are high.
- `app_wdf_data`  out  128  write beat.
- `app_wdf_wren`  out  1  write beat valid.
- `app_wdf_end`  out  1  equals `app_wdf_wren`; every beat is the last beat of its command.
- `app_wdf_mask`  out  16  constant 0.
- `app_wdf_rdy`  in  1  write beat accepted when both `app_wdf_wren` and `app_wdf_rdy` are high.
- `app_rd_data`  in  128  read beat.
- `app_rd_data_valid`  in  1  read beat strobe. Beats return in command order.
- `state_value`  out  16  debug word.

## Operation
- Address mapping: beat b (0 or 1) uses `app_addr` = {`ctrl_addr_i[28:5]`, b, 3'b000}. Beat 0 carries line bits [127:0]; beat 1 carries [255:128].
- States: CALIB, BOOT_ACK, IDLE, WR_DATA, WR_CMD, RD, ACK.
- CALIB
  - Wait for `init_calib_complete`=1, then go to BOOT_ACK.
  - Requests are ignored.
- BOOT_ACK
  - `ctrl_ack_o`=1 for exactly one cycle, then go to IDLE.
- IDLE
  - Sample requests.
  - `ctrl_we_i`=1: latch address and data, then go to WR_DATA. Write has priority if both requests are high.
  - Else `ctrl_rd_i`=1: latch address, then go to RD.
- WR_DATA
  - Drive beat 0, then beat 1, with `app_wdf_wren`=1.
  - The beat index advances only on an accepted beat (`app_wdf_wren`=1 and `app_wdf_rdy`=1).
  - After beat 1 is accepted, go to WR_CMD.
- WR_CMD
  - Issue write command 0, then command 1, with `app_en`=1; each advances only when `app_rdy`=1.
  - After command 1 is accepted, go to ACK.
- RD
  - Command counter: issue read commands 0 and 1, gated by `app_rdy`.
  - Beat counter (independent): capture each `app_rd_data_valid` beat into line half 0, then half 1. Beats may arrive before command 1 is issued.
  - After beat 1 is captured, go to ACK.
- ACK
  - `ctrl_ack_o`=1 for one cycle, with `ctrl_data_o` holding the captured line; then go to IDLE.
  - The request input is still high during the ACK cycle. Because the next sample is taken in IDLE, a back-to-back write-then-read from the cache is served correctly.
- `app_rd_data_valid` outside RD is ignored, including stale beats after a reset.
- `ctrl_data_o` holds its value until the next read completes.

## Timing
- Reset values
  - State: CALIB.
  - All outputs 0: `ctrl_ack_o`, `ctrl_data_o`, `app_en`, `app_wdf_wren`, `app_wdf_end`, `app_addr`, `app_cmd`, `app_wdf_data`, `state_value`.
- Reset mid-operation aborts the transaction with no ack. Partially issued MIG commands are abandoned.
- All outputs are registered.
- Write latency with the MIG always ready:
  - Request sampled in IDLE at cycle T.
  - Beats at T+1 and T+2.
  - Commands at T+3 and T+4.
  - `ctrl_ack_o` at T+5.
- Read latency: `ctrl_ack_o` occurs on the cycle after the second `app_rd_data_valid`.
- Any stall (`app_rdy`=0 or `app_wdf_rdy`=0) holds `app_addr`, `app_cmd`, `app_en`, `app_wdf_data` and `app_wdf_wren` stable.
- There is exactly one `ctrl_ack_o` per request, plus one boot ack after each calibration or reset.

## Configuration
- `DDR3_BRIDGE_DEBUG_EN`
  - Defined: `state_value` = {12-bit count of completed line transactions (wraps at 4095→0), 4-bit state code}. State codes: CALIB=0, BOOT_ACK=1, IDLE=2, WR_DATA=3, WR_CMD=4, RD=5, ACK=6.
  - Undefined: `state_value` is constant 0 and the counter is not built.

## Test plan
- Reset, then hold `init_calib_complete`=0 for 20 cycles, then raise it -> no ack during the wait; one ack 2 cycles after the rise; IDLE reached.
- Write to 0x0000_0120, data = {128'hB…B, 128'hA…A}, MIG always ready:
  - Beats A then B.
  - Commands at `app_addr` 0x0000090 and 0x0000098 with `app_cmd`=0.
  - Ack at T+5.
- Read of 0x1FFF_FFE0 with beats arriving 7 and 9 cycles after the first command -> `ctrl_data_o` = {beat1, beat0}; ack on the cycle after beat 1.
- Stalls: `app_wdf_rdy` low for 3 cycles on beat 1 and `app_rdy` low for 2 cycles on command 0 -> outputs stable during each stall; still one ack.
- Write ack immediately followed by a read request -> read accepted in the next IDLE; two distinct acks.
- `rst` pulsed while in RD, then a stray `app_rd_data_valid` arrives -> no ack for the aborted read; stray beat ignored; boot ack after calibration.
